// File: rtl/gmii_tx_engine_if.sv
// Read port and pointer exchange between the TX frame buffer and the GMII transmit engine.
// The engine owns the read address and consumed pointer; the buffer side supplies data and the host write pointer.
interface gmii_tx_engine_if;
  logic [11:0] wr_ptr;
  logic [11:0] rd_addr;
  logic [15:0] rd_data;
  logic [11:0] rd_ptr;

  modport master (
    input  wr_ptr,
    input  rd_data,
    output rd_addr,
    output rd_ptr
  );

  modport slave (
    output wr_ptr,
    output rd_data,
    input  rd_addr,
    input  rd_ptr
  );
endinterface

// File: rtl/gmii_tx_engine.sv
// Drains length-prefixed frames from a 4096x16 buffer onto GMII with preamble/SFD,
// zero padding to 60 bytes, CRC-32 FCS and a 12-cycle inter-frame gap.
module gmii_tx_engine (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               tx_enable,
  gmii_tx_engine_if.master   buf_if,
  output logic [7:0]         gmii_txd,
  output logic               gmii_tx_en,
  output logic [15:0]        frame_cnt,
  output logic               err
);

  localparam logic [10:0] MAX_LEN   = 11'd1514;
  localparam logic [10:0] MIN_BYTES = 11'd60;
  localparam logic [10:0] PRE_BYTES = 11'd8;
  localparam logic [10:0] FCS_BYTES = 11'd4;
  localparam logic [10:0] IFG_CYC   = 11'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CHECK,
    S_PRE,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  txd_reg, txd_next;
  logic        tx_en_reg, tx_en_next;
  logic [11:0] rd_addr_reg, rd_addr_next;
  logic [11:0] rd_ptr_reg, rd_ptr_next;
  logic [10:0] len_reg, len_next;
  logic [10:0] cnt_reg, cnt_next;
  logic [7:0]  low_byte_reg, low_byte_next;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic        err_reg, err_next;
  logic        fcs_start;

  logic [10:0] hdr_len;
  logic [11:0] avail;
  logic [11:0] need_words;
  logic [11:0] next_hdr;
  logic [31:0] crc_folded;
  logic [7:0]  fcs_byte;

  // One byte through the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data_in);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ({1'b0, c[31:1]} ^ 32'hEDB88320) : {1'b0, c[31:1]};
    end
    return c;
  endfunction

  assign hdr_len    = buf_if.rd_data[10:0];
  assign avail      = buf_if.wr_ptr - rd_ptr_reg;
  assign need_words = 12'd1 + (({1'b0, hdr_len} + 12'd1) >> 1);
  assign next_hdr   = rd_ptr_reg + 12'd1 + (({1'b0, len_reg} + 12'd1) >> 1);

  // The CRC trails the wire by one byte: it folds in the payload byte currently on gmii_txd.
  assign crc_folded = crc_byte(crc_reg, txd_reg);

  always_comb begin
    fcs_byte = 8'h00;
    case (cnt_reg[1:0])
      2'd1:    fcs_byte = crc_reg[15:8];
      2'd2:    fcs_byte = crc_reg[23:16];
      2'd3:    fcs_byte = crc_reg[31:24];
      default: fcs_byte = crc_reg[7:0];
    endcase
  end

  // Next-state logic computes the byte for the following cycle so the wire outputs stay registered.
  always_comb begin
    state_next     = state_reg;
    txd_next       = 8'h00;
    tx_en_next     = 1'b0;
    rd_addr_next   = rd_addr_reg;
    rd_ptr_next    = rd_ptr_reg;
    len_next       = len_reg;
    cnt_next       = cnt_reg;
    low_byte_next  = low_byte_reg;
    crc_next       = crc_reg;
    frame_cnt_next = frame_cnt_reg;
    err_next       = err_reg;
    fcs_start      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (tx_enable && (avail != 12'd0)) begin
          rd_addr_next = rd_ptr_reg;
          state_next   = S_HDR;
        end
      end

      S_HDR: begin
        state_next = S_CHECK;
      end

      S_CHECK: begin
        len_next = hdr_len;
        if ((hdr_len == 11'd0) || (hdr_len > MAX_LEN)) begin
          err_next    = 1'b1;
          rd_ptr_next = buf_if.wr_ptr;
          state_next  = S_IDLE;
        end else if (avail >= need_words) begin
          state_next   = S_PRE;
          txd_next     = 8'h55;
          tx_en_next   = 1'b1;
          cnt_next     = 11'd1;
          rd_addr_next = rd_ptr_reg + 12'd1;
          crc_next     = 32'hFFFFFFFF;
        end
      end

      S_PRE: begin
        tx_en_next = 1'b1;
        if (cnt_reg == PRE_BYTES) begin
          state_next    = S_DATA;
          txd_next      = buf_if.rd_data[15:8];
          low_byte_next = buf_if.rd_data[7:0];
          rd_addr_next  = rd_addr_reg + 12'd1;
          cnt_next      = 11'd1;
        end else begin
          txd_next = (cnt_reg == PRE_BYTES - 11'd1) ? 8'hD5 : 8'h55;
          cnt_next = cnt_reg + 11'd1;
        end
      end

      S_DATA: begin
        tx_en_next = 1'b1;
        crc_next   = crc_folded;
        if (cnt_reg < len_reg) begin
          cnt_next = cnt_reg + 11'd1;
          // Even byte index starts a new word; its low half is parked for the next cycle.
          if (!cnt_reg[0]) begin
            txd_next      = buf_if.rd_data[15:8];
            low_byte_next = buf_if.rd_data[7:0];
            rd_addr_next  = rd_addr_reg + 12'd1;
          end else begin
            txd_next = low_byte_reg;
          end
        end else if (cnt_reg < MIN_BYTES) begin
          state_next = S_PAD;
          cnt_next   = cnt_reg + 11'd1;
        end else begin
          fcs_start = 1'b1;
        end
      end

      S_PAD: begin
        tx_en_next = 1'b1;
        crc_next   = crc_folded;
        if (cnt_reg < MIN_BYTES) begin
          cnt_next = cnt_reg + 11'd1;
        end else begin
          fcs_start = 1'b1;
        end
      end

      S_FCS: begin
        if (cnt_reg == FCS_BYTES) begin
          state_next = S_IFG;
          cnt_next   = 11'd1;
        end else begin
          tx_en_next = 1'b1;
          txd_next   = ~fcs_byte;
          cnt_next   = cnt_reg + 11'd1;
        end
      end

      S_IFG: begin
        if (cnt_reg == IFG_CYC) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 11'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // crc_next already holds the final folded CRC; emit its complement, low byte first.
    if (fcs_start) begin
      state_next     = S_FCS;
      txd_next       = ~crc_folded[7:0];
      tx_en_next     = 1'b1;
      cnt_next       = 11'd1;
      rd_ptr_next    = next_hdr;
      frame_cnt_next = frame_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= S_IDLE;
      txd_reg       <= 8'h00;
      tx_en_reg     <= 1'b0;
      rd_addr_reg   <= 12'd0;
      rd_ptr_reg    <= 12'd0;
      len_reg       <= 11'd0;
      cnt_reg       <= 11'd0;
      low_byte_reg  <= 8'h00;
      crc_reg       <= 32'hFFFFFFFF;
      frame_cnt_reg <= 16'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      txd_reg       <= txd_next;
      tx_en_reg     <= tx_en_next;
      rd_addr_reg   <= rd_addr_next;
      rd_ptr_reg    <= rd_ptr_next;
      len_reg       <= len_next;
      cnt_reg       <= cnt_next;
      low_byte_reg  <= low_byte_next;
      crc_reg       <= crc_next;
      frame_cnt_reg <= frame_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign gmii_txd       = txd_reg;
  assign gmii_tx_en     = tx_en_reg;
  assign buf_if.rd_addr = rd_addr_reg;
  assign buf_if.rd_ptr  = rd_ptr_reg;
  assign frame_cnt      = frame_cnt_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_gmii_tx_engine.sv
// Directed bench for gmii_tx_engine: a behavioural buffer plus a byte scoreboard
// filled when frames are written and drained by a GMII monitor.
module tb_gmii_tx_engine;

  logic        sys_clk;
  logic        sys_rst;
  logic        tx_enable;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic [15:0] frame_cnt;
  logic        err;

  gmii_tx_engine_if bif ();

  gmii_tx_engine dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .tx_enable  (tx_enable),
    .buf_if     (bif),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .frame_cnt  (frame_cnt),
    .err        (err)
  );

  logic [15:0] mem [0:4095];
  logic [7:0]  exp_q [$];
  int          len_q [$];

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int en_run     = 0;
  int low_run    = 0;
  int last_gap   = 0;
  int en_seen    = 0;
  bit mon_en     = 1'b1;

  initial sys_clk = 1'b0;
  always #4 sys_clk = ~sys_clk;

  always @(posedge sys_clk) bif.rd_data <= mem[bif.rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Writes a frame into the buffer and queues every byte expected on the wire.
  task automatic add_frame(input logic [11:0] addr, input int len, input logic [4:0] hdr_hi, input int seed);
    logic [31:0] crc;
    logic [7:0]  b;
    logic [11:0] wa;
    int          total;
    mem[addr] = {hdr_hi, 11'(len)};
    for (int k = 0; k < 8; k++) exp_q.push_back((k == 7) ? 8'hD5 : 8'h55);
    crc   = 32'hFFFFFFFF;
    total = (len < 60) ? 60 : len;
    for (int k = 0; k < total; k++) begin
      if (k < len) begin
        b  = 8'(seed + k);
        wa = addr + 12'd1 + 12'(k / 2);
        if (k % 2 == 0) mem[wa][15:8] = b;
        else            mem[wa][7:0]  = b;
      end else begin
        b = 8'h00;
      end
      exp_q.push_back(b);
      crc = crc_upd(crc, b);
    end
    if (len % 2 == 1) begin
      wa = addr + 12'd1 + 12'(len / 2);
      mem[wa][7:0] = 8'hEE;
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(~(crc >> (8 * k))));
    len_q.push_back(8 + total + 4);
  endtask

  // GMII monitor: byte-by-byte scoreboard compare, burst length and inter-burst gap.
  always @(negedge sys_clk) begin
    if (sys_rst || !mon_en) begin
      en_run  = 0;
      low_run = 0;
    end else if (gmii_tx_en) begin
      if (en_run == 0) last_gap = low_run;
      en_run++;
      en_seen++;
      chk("tx_byte_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) chk("gmii_txd", {24'd0, gmii_txd}, {24'd0, exp_q.pop_front()});
    end else begin
      if (en_run != 0) begin
        chk("burst_expected", (len_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (len_q.size() != 0) chk("tx_en_length", 32'(en_run), 32'(len_q.pop_front()));
        en_run  = 0;
        low_run = 0;
      end
      low_run++;
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst     = 1'b1;
    tx_enable   = 1'b0;
    bif.wr_ptr  = 12'd0;
    repeat (3) step();
    sys_rst   = 1'b0;
    tx_enable = 1'b1;
    step();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && len_q.size() == 0 && !gmii_tx_en) && n < 3000) begin
      step();
      n++;
    end
    chk(tag, (exp_q.size() == 0 && len_q.size() == 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en0;

    // Reset state
    sys_rst    = 1'b1;
    tx_enable  = 1'b0;
    bif.wr_ptr = 12'd0;
    repeat (3) step();
    chk("rst_txd", {24'd0, gmii_txd}, 32'h00);
    chk("rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
    chk("rst_rd_addr", {20'd0, bif.rd_addr}, 32'h000);
    chk("rst_rd_ptr", {20'd0, bif.rd_ptr}, 32'h000);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    sys_rst = 1'b0;
    step();

    // 60-byte frame, bytes 0x00..0x3B, header upper bits set (ignored); latency 3
    add_frame(12'h000, 60, 5'h1F, 0);
    bif.wr_ptr = 12'h01F;
    tx_enable  = 1'b1;
    step();
    step();
    chk("lat_low_cycle2", {31'd0, gmii_tx_en}, 32'd0);
    step();
    chk("lat_high_cycle3", {31'd0, gmii_tx_en}, 32'd1);
    wait_done("t1_done");
    chk("t1_rd_ptr", {20'd0, bif.rd_ptr}, 32'h01F);
    chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 42-byte frame padded to 60
    do_reset();
    add_frame(12'h000, 42, 5'h10, 8'h90);
    bif.wr_ptr = 12'h016;
    wait_done("t2_done");
    chk("t2_rd_ptr", {20'd0, bif.rd_ptr}, 32'h016);
    chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // Back-to-back L=61 then L=100
    do_reset();
    add_frame(12'h000, 61, 5'h00, 8'h21);
    add_frame(12'h020, 100, 5'h00, 8'hC7);
    bif.wr_ptr = 12'h053;
    n = 0;
    while (frame_cnt != 16'd1 && n < 2000) begin step(); n++; end
    chk("t3_first_fcs_seen", {16'd0, frame_cnt}, 32'd1);
    chk("t3_first_rd_ptr", {20'd0, bif.rd_ptr}, 32'h020);
    wait_done("t3_done");
    chk("t3_gap", 32'(last_gap), 32'd15);
    chk("t3_rd_ptr", {20'd0, bif.rd_ptr}, 32'h053);
    chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // L=0 header discards up to wr_ptr, then a frame straddling 0xFFF->0x000
    do_reset();
    mem[12'h000] = 16'h0000;
    bif.wr_ptr   = 12'hFF0;
    repeat (6) step();
    chk("t4_err_len0", {31'd0, err}, 32'd1);
    chk("t4_discard_rd_ptr", {20'd0, bif.rd_ptr}, 32'hFF0);
    add_frame(12'hFF0, 64, 5'h00, 8'h40);
    bif.wr_ptr = 12'h011;
    wait_done("t4_done");
    chk("t4_rd_ptr", {20'd0, bif.rd_ptr}, 32'h011);
    chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // Partial frame holds in CHECK until enough words are present
    do_reset();
    add_frame(12'h000, 100, 5'h00, 8'h03);
    bif.wr_ptr = 12'h010;
    en0 = en_seen;
    repeat (200) step();
    chk("t5_no_tx_while_partial", 32'(en_seen), 32'(en0));
    bif.wr_ptr = 12'h033;
    step();
    step();
    chk("t5_tx_en_within_2", {31'd0, gmii_tx_en}, 32'd1);
    wait_done("t5_done");
    chk("t5_rd_ptr", {20'd0, bif.rd_ptr}, 32'h033);

    // Oversize header L=0x700
    do_reset();
    mem[12'h000] = 16'h0700;
    bif.wr_ptr   = 12'h040;
    en0 = en_seen;
    repeat (10) step();
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_rd_ptr", {20'd0, bif.rd_ptr}, 32'h040);
    chk("t6_no_tx", 32'(en_seen), 32'(en0));
    chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // Reset mid-DATA abandons the frame
    do_reset();
    chk("t7_err_cleared", {31'd0, err}, 32'd0);
    add_frame(12'h000, 100, 5'h00, 8'h77);
    bif.wr_ptr = 12'h033;
    n = 0;
    while (!gmii_tx_en && n < 50) begin step(); n++; end
    chk("t7_tx_started", {31'd0, gmii_tx_en}, 32'd1);
    repeat (30) step();
    mon_en  = 1'b0;
    sys_rst = 1'b1;
    step();
    chk("t7_rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
    chk("t7_rst_rd_ptr", {20'd0, bif.rd_ptr}, 32'h000);
    chk("t7_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    tx_enable  = 1'b0;
    bif.wr_ptr = 12'd0;
    exp_q.delete();
    len_q.delete();
    step();
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    repeat (5) step();
    chk("t7_idle_after_rst", {31'd0, gmii_tx_en}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/gmii_tx_engine.md
# gmii_tx_engine

Transmit-side PHY stage downstream of the host-written TX frame buffer (tx0mem) in ethpipe_mid. It drains length-prefixed frames from the 4096×16 buffer between its own read pointer and the host-supplied write pointer. Each frame goes out on GMII with preamble/SFD, zero padding to 60 bytes, Ethernet FCS and inter-frame gap. The engine returns the consumed read pointer to the PCIe side for credit/space accounting.

## Interface
- (no parameters; buffer depth fixed at 4096 words, max frame 1514 bytes)
- sys_clk  in  1  125 MHz clock, shared with GMII TX (gmii_tx_clk domain)
- sys_rst  in  1  synchronous, active-high reset
- tx_enable  in  1  sampled only in IDLE; deassert mid-frame completes current frame
- wr_ptr  in  12  host write pointer (word address of next unwritten word)
- rd_addr  out  12  buffer read address; rd_data valid exactly 1 cycle later
- rd_data  in  16  buffer read data; high byte transmitted first
- rd_ptr  out  12  word address of next unconsumed frame header
- gmii_txd  out  8  GMII transmit data
- gmii_tx_en  out  1  GMII transmit enable
- frame_cnt  out  16  frames transmitted, wraps
- err  out  1  sticky: invalid length header seen; cleared only by reset

## Operation
- Frame in buffer: header word [10:0] = byte length L (bits 15:11 ignored), then ceil(L/2) data words; next header at start + 1 + ceil(L/2), modulo 4096.
- Valid L: 1..1514. L = 0 or L > 1514: set err, load rd_ptr <= wr_ptr (discard pending), return to IDLE, no tx_en.
- Available words = (wr_ptr − rd_ptr) mod 4096; empty when equal.
- States: IDLE → HDR → CHECK → PRE → DATA → [PAD] → FCS → IFG → IDLE.
  - IDLE: if tx_enable and not empty, rd_addr <= rd_ptr, go HDR.
  - HDR: one cycle for header read latency; go CHECK.
  - CHECK: latch L. Validate it. Wait until available ≥ 1 + ceil(L/2), then go PRE.
  - PRE: 7× 0x55 then 0xD5, 8 cycles.
  - DATA: L bytes. Fetch the next word every second cycle. For odd L the low byte of the last word is discarded.
  - PAD: 0x00 bytes until 60 bytes sent; skipped when L ≥ 60.
  - FCS: 4 bytes, CRC-32 LSB byte first. On entry rd_ptr <= next header address and frame_cnt += 1.
  - IFG: 12 cycles with tx_en low.
- CRC-32: IEEE polynomial, reflected (0xEDB88320), init 0xFFFFFFFF, byte-serial LSB-first. Covers data and pad only. Transmitted value is the complement.
- wr_ptr changes are tolerated at any time. Only the CHECK availability test and the IDLE empty test use it.

## Timing
- Reset values: gmii_txd 0x00, gmii_tx_en 0, rd_addr 0, rd_ptr 0, frame_cnt 0, err 0, state IDLE. Reset mid-frame drops tx_en on the next edge, and the partial frame is abandoned.
- Latency: with a complete frame present and tx_enable high in IDLE at cycle 0, the first preamble byte appears with gmii_tx_en = 1 at cycle 3.
- gmii_tx_en stays high exactly 8 + max(L,60) + 4 consecutive cycles; gmii_txd and gmii_tx_en are registered.
- rd_ptr updates on the first FCS cycle.
- Back-to-back frames: gap between tx_en low and the next tx_en high is exactly 15 cycles (12 IFG + IDLE/HDR/CHECK).
- Address arithmetic is 12-bit modulo. A frame may straddle 0xFFF → 0x000.
- Partial frame (header present, data incomplete): the engine holds in CHECK with tx_en low indefinitely. No timeout.

## Test plan
- 60-byte frame at 0x000, bytes 0x00..0x3B, wr_ptr = 0x01F → tx_en high 72 cycles; 55×7, D5, data, FCS matching the model; rd_ptr = 0x01F; frame_cnt = 1.
- 42-byte frame → 42 data bytes + 18 × 0x00, tx_en 72 cycles, FCS over all 60 bytes; rd_ptr = 0x016.
- Two back-to-back frames, L = 61 then 100 → first rd_ptr = 0x020 with the last word's low byte unused; exactly 15 idle cycles between frames; final rd_ptr = 0x053.
- Frame with header at 0xFF0, L = 64, wr_ptr = 0x011 → contiguous 64 data bytes across the wrap; rd_ptr = 0x011.
- Header L = 100 at 0x000 with wr_ptr = 0x010 → no tx_en for 200 cycles. Then wr_ptr = 0x033 → tx_en rises within 2 cycles.
- Header L = 0x700 with wr_ptr = 0x040 → err = 1, rd_ptr = 0x040, tx_en never asserted. Also: reset asserted mid-DATA → tx_en 0 next cycle, rd_ptr 0, frame_cnt 0.
